mac_operand_loader: RTL
=======================

Name: mac_operand_loader

Overview:
Input stage directly upstream of the MAC accelerator core.
- Takes the byte-wide pin stream (dedicated input byte plus strobe/command bits).
- Assembles consecutive bytes into (A, B) operand pairs and buffers them in a small first-word-fall-through FIFO.
- Presents the pairs to the MAC core over a valid/ready handshake, together with per-pair "last" tagging and an accumulator-clear pulse.

Parameters:
DATA_W, 8, operand width in bits (equals pin byte width)
FIFO_DEPTH, 4, number of buffered operand pairs; power of two, >= 2
LVL_W, 3, width of fifo_level; must hold 0..FIFO_DEPTH

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
ena  input  1  design-selected enable; gates the byte input side only
byte_in  input  DATA_W  operand byte from ui_in
byte_valid  input  1  byte_in valid this cycle (uio_in[0])
cmd_last  input  1  sampled with the B byte; tags the pair as last of a dot product (uio_in[1])
cmd_clear  input  1  flush the loader and request an accumulator clear (uio_in[2])
a_out  output  DATA_W  operand A at FIFO head
b_out  output  DATA_W  operand B at FIFO head
last_out  output  1  last tag at FIFO head
pair_valid  output  1  FIFO non-empty
pair_ready  input  1  MAC core accepts head pair this cycle
clear_acc  output  1  one-cycle pulse telling the MAC core to zero its accumulator
busy  output  1  high in state WAIT_B or when the FIFO is non-empty
overflow_err  output  1  sticky: a completed pair was dropped because the FIFO was full
fifo_level  output  LVL_W  current FIFO occupancy

Behaviour:
- Clock and reset: clk is the only clock. rst is synchronous and active-high, sampled on the rising edge.
- While rst is high:
  - state = WAIT_A, FIFO emptied (level 0), A holding register = 0.
  - Outputs: a_out = 0, b_out = 0, last_out = 0, pair_valid = 0, clear_acc = 0, busy = 0, overflow_err = 0, fifo_level = 0.
  - Reset mid-pair discards the held A byte.
- Input acceptance: a byte is accepted in a cycle iff ena && byte_valid && !cmd_clear. With ena low, byte_valid and cmd_last are ignored.
- FSM has two states.
  - WAIT_A: an accepted byte is latched into the A register; next state WAIT_B.
  - WAIT_B: an accepted byte is B; {A, B, cmd_last} is pushed if permitted; next state WAIT_A whether or not the push happened.
- Push permitted iff fifo_level < FIFO_DEPTH, or a pop occurs in the same cycle.
  - Full with no pop: the pair is dropped, overflow_err is set, and the FSM still returns to WAIT_A (byte framing preserved).
- Pop occurs when pair_valid && pair_ready.
  - The head advances on that edge.
  - pair_ready while empty has no effect.
- Simultaneous push and pop: the level is unchanged. When the FIFO was empty, the pushed pair becomes the head on the next cycle.
- Latency: B accepted at edge N into an empty FIFO gives pair_valid = 1 with the new a_out/b_out/last_out in the cycle after edge N (one cycle). No combinational path from byte_in to the outputs.
- Head outputs: a_out/b_out/last_out are held stable while pair_valid && !pair_ready. When pair_valid = 0 they are 0.
- Read/write pointers wrap modulo FIFO_DEPTH. fifo_level is exact 0..FIFO_DEPTH.
- cmd_clear is acted on regardless of ena. When sampled high at edge N:
  - FIFO flushed (level 0, pair_valid 0), state goes to WAIT_A, overflow_err cleared.
  - clear_acc = 1 for exactly the cycle after edge N.
  - It takes precedence over byte_valid and pair_ready in the same cycle: no push, no pop.
  - cmd_clear held for k cycles gives clear_acc high for k cycles.
- overflow_err is cleared only by rst or cmd_clear.
- busy = (state == WAIT_B) || (fifo_level != 0); it is registered-state derived.

Test Plan:
- Reset, then bytes 0x03, 0x05 with cmd_last=1 on the second, pair_ready=0 → pair_valid rises the cycle after 0x05; a_out=0x03, b_out=0x05, last_out=1, fifo_level=1, held stable; then pair_ready=1 for one cycle → pair_valid=0, level 0.
- pair_ready=0, send 5 pairs (0x01..0x0A) → first 4 pairs buffered (level 4), 5th dropped, overflow_err=1; drain with pair_ready=1 → heads (01,02),(03,04),(05,06),(07,08) in order, pointers wrap correctly on the refill that follows.
- Full FIFO and pair_ready=1 in the same cycle the B byte is accepted → push and pop both occur, level stays 4, overflow_err stays 0.
- Send A=0x11 only, then cmd_clear=1 with byte_valid=1, byte_in=0x22 → clear_acc pulses one cycle, state WAIT_A, level 0, overflow_err 0; next bytes 0x33, 0x44 form the pair (0x33, 0x44).
- ena=0 while byte_valid toggles with bytes 0xAA, 0xBB → no state change, pair_valid stays 0, busy stays 0; re-assert ena and resume a normal pair.
- Assert rst while in WAIT_B with 2 pairs buffered → next cycle all outputs 0, level 0; next byte accepted is treated as A.

Source files
------------

// File: rtl/mac_operand_loader.sv
// Byte-stream to operand-pair loader for the MAC core: pairs consecutive bytes
// into (A, B, last) entries and buffers them in a small FWFT FIFO.
module mac_operand_loader #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              byte_valid,
  input  logic              cmd_last,
  input  logic              cmd_clear,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              last_out,
  output logic              pair_valid,
  input  logic              pair_ready,
  output logic              clear_acc,
  output logic              busy,
  output logic              overflow_err,
  output logic [LVL_W-1:0]  fifo_level
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    WAIT_A = 1'b0,
    WAIT_B = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  aHold_q, aHold_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               overflow_q, overflow_d;
  logic               clearAcc_q, clearAcc_d;

  logic [DATA_W-1:0]  memA_q [FIFO_DEPTH];
  logic [DATA_W-1:0]  memB_q [FIFO_DEPTH];
  logic               memL_q [FIFO_DEPTH];

  logic accept;
  logic notEmpty;
  logic pushReq;
  logic push;
  logic pop;

  // cmd_clear dominates: it blocks byte acceptance and head consumption alike.
  always_comb begin
    notEmpty = (level_q != '0);
    accept   = ena && byte_valid && !cmd_clear;
    pop      = notEmpty && pair_ready && !cmd_clear;
    pushReq  = accept && (state_q == WAIT_B);
    push     = pushReq && ((level_q < DEPTH_LVL) || pop);
  end

  always_comb begin
    state_d    = state_q;
    aHold_d    = aHold_q;
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = wrPtr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    clearAcc_d = 1'b0;

    if (cmd_clear) begin
      state_d    = WAIT_A;
      rdPtr_d    = '0;
      wrPtr_d    = '0;
      level_d    = '0;
      overflow_d = 1'b0;
      clearAcc_d = 1'b1;
    end else begin
      if (accept) begin
        unique case (state_q)
          WAIT_A: begin
            aHold_d = byte_in;
            state_d = WAIT_B;
          end
          WAIT_B: begin
            // A dropped pair still consumes the B byte so framing stays aligned.
            state_d = WAIT_A;
            if (!push) begin
              overflow_d = 1'b1;
            end
          end
          default: state_d = WAIT_A;
        endcase
      end

      if (push) begin
        wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WAIT_A;
      aHold_q    <= '0;
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      clearAcc_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      aHold_q    <= aHold_d;
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      clearAcc_q <= clearAcc_d;
    end
  end

  // Storage needs no reset: the head outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      memA_q[wrPtr_q] <= aHold_q;
      memB_q[wrPtr_q] <= byte_in;
      memL_q[wrPtr_q] <= cmd_last;
    end
  end

  always_comb begin
    pair_valid   = notEmpty;
    a_out        = notEmpty ? memA_q[rdPtr_q] : '0;
    b_out        = notEmpty ? memB_q[rdPtr_q] : '0;
    last_out     = notEmpty ? memL_q[rdPtr_q] : 1'b0;
    clear_acc    = clearAcc_q;
    busy         = (state_q == WAIT_B) || notEmpty;
    overflow_err = overflow_q;
    fifo_level   = level_q;
  end

endmodule
